// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder composed of two half adders and an OR gate.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_ha0_s;
    logic w_ha0_c;
    logic w_ha1_c;

    // first half adder combines the operands, second folds in the carry
    assign w_ha0_s = a ^ b;
    assign w_ha0_c = a & b;
    assign s       = w_ha0_s ^ ci;
    assign w_ha1_c = w_ha0_s & ci;
    assign co      = w_ha0_c | w_ha1_c;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: shares one full adder across all WIDTH bit positions,
// LSB first, with valid/ready handshakes on request and result.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             busy
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_fa_s;
    logic             w_fa_co;
    logic             w_accept;
    logic             w_last_bit;

    full_adder u_full_adder (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    assign w_accept   = start_valid && (r_state == IDLE);
    assign w_last_bit = (r_bit_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_state_nxt = RUN;
            RUN:     if (w_last_bit)  w_state_nxt = DONE;
            DONE:    if (done_ready)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter holds at WIDTH-1 on the final bit so it never wraps mid-operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_sum_sr  <= '0;
            r_carry   <= 1'b0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_a_sr    <= a_in;
            r_b_sr    <= b_in;
            r_sum_sr  <= '0;
            r_carry   <= cin;
            r_bit_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a_sr    <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr    <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_sum_sr  <= {w_fa_s, r_sum_sr[WIDTH-1:1]};
            r_carry   <= w_fa_co;
            if (!w_last_bit) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign start_ready = (r_state == IDLE);
    assign done_valid  = (r_state == DONE);
    assign busy        = (r_state == RUN) || (r_state == DONE);
    assign sum_out     = r_sum_sr;
    assign cout        = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl against an arithmetic model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] sum_out;
    logic         cout;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin         (cin),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum_out     (sum_out),
        .cout        (cout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Model: an operation is the triple (a, b, cin) plus how many bits have
    // been processed; visible outputs follow from plain addition of the low k bits.
    logic         m_busy;
    int           m_k;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_cin;

    function automatic logic [W:0] partial_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input logic c, input int k);
        longint unsigned mask;
        longint unsigned p;
        longint unsigned s;
        mask = (64'd1 << k) - 64'd1;
        p    = (a & mask) + (b & mask) + c;
        s    = ((p & mask) << (W - k)) & ((64'd1 << W) - 64'd1);
        return {1'(p >> k), W'(s)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_a    <= '0;
            m_b    <= '0;
            m_cin  <= 1'b0;
        end else if (!m_busy) begin
            if (start_valid) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_a    <= a_in;
                m_b    <= b_in;
                m_cin  <= cin;
            end
        end else if (m_k < W) begin
            m_k <= m_k + 1;
        end else if (done_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst) begin
            e = partial_result(m_a, m_b, m_cin, m_k);
            check("model start_ready", 32'(start_ready), 32'(!m_busy));
            check("model busy",        32'(busy),        32'(m_busy));
            check("model done_valid",  32'(done_valid),  32'(m_busy && (m_k == W)));
            check("model sum_out",     32'(sum_out),     32'(e[W-1:0]));
            check("model cout",        32'(cout),        32'(e[W]));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int hold, input bit noise,
                          output logic [W-1:0] res_sum, output logic res_cout);
        int           edges;
        logic [W-1:0] held;
        @(negedge clk);
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
        cin         = c;
        done_ready  = 1'b0;
        @(posedge clk);
        edges = 0;
        forever begin
            @(negedge clk);
            if (done_valid || edges >= 100) break;
            edges++;
            start_valid = noise ? 1'($urandom) : 1'b0;
            done_ready  = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
                cin  = 1'($urandom);
            end
        end
        check("latency edges", 32'(edges), 32'(W));
        done_ready = 1'b0;
        held = sum_out;
        for (int h = 0; h < hold; h++) begin
            start_valid = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            check("hold done_valid", 32'(done_valid), 32'd1);
            check("hold sum_out",    32'(sum_out),    32'(held));
        end
        done_ready  = 1'b1;
        start_valid = noise;
        @(negedge clk);
        done_ready  = 1'b0;
        start_valid = 1'b0;
        check("post handshake start_ready", 32'(start_ready), 32'd1);
        check("post handshake done_valid",  32'(done_valid),  32'd0);
        res_sum  = sum_out;
        res_cout = cout;
    endtask

    initial begin
        logic [W-1:0] s;
        logic         co;
        logic [W:0]   ref_v;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst         = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        a_in        = '0;
        b_in        = '0;
        cin         = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset start_ready", 32'(start_ready), 32'd1);
        check("reset busy",        32'(busy),        32'd0);

        run_op(8'h5A, 8'h33, 1'b0, 0, 1'b0, s, co);
        check("5A+33 sum",  32'(s),  32'h8D);
        check("5A+33 cout", 32'(co), 32'd0);

        // asynchronous reset mid-cycle, away from any clock edge
        #3 rst = 1'b1;
        #1;
        check("async rst start_ready", 32'(start_ready), 32'd1);
        check("async rst done_valid",  32'(done_valid),  32'd0);
        check("async rst busy",        32'(busy),        32'd0);
        check("async rst sum_out",     32'(sum_out),     32'h00);
        check("async rst cout",        32'(cout),        32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'hFF, 8'h01, 1'b0, 1, 1'b0, s, co);
        check("FF+01 sum",  32'(s),  32'h00);
        check("FF+01 cout", 32'(co), 32'd1);

        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, s, co);
        check("FF+FF+1 sum",  32'(s),  32'hFF);
        check("FF+FF+1 cout", 32'(co), 32'd1);

        run_op(8'h10, 8'h20, 1'b0, 5, 1'b1, s, co);
        check("10+20 sum",  32'(s),  32'h30);
        check("10+20 cout", 32'(co), 32'd0);

        // abort once three bits have been processed
        @(negedge clk);
        start_valid = 1'b1;
        a_in        = 8'h77;
        b_in        = 8'h11;
        cin         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort start_ready", 32'(start_ready), 32'd1);
        check("abort done_valid",  32'(done_valid),  32'd0);
        check("abort busy",        32'(busy),        32'd0);
        check("abort sum_out",     32'(sum_out),     32'h00);
        check("abort cout",        32'(cout),        32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("abort no done_valid", 32'(done_valid), 32'd0);
        end

        run_op(8'h01, 8'h02, 1'b1, 0, 1'b0, s, co);
        check("01+02+1 sum",  32'(s),  32'h04);
        check("01+02+1 cout", 32'(co), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra    = W'($urandom);
            rb    = W'($urandom);
            rc    = 1'($urandom);
            ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), bit'($urandom), s, co);
            check("random sum",  32'(s),  32'(ref_v[W-1:0]));
            check("random cout", 32'(co), 32'(ref_v[W]));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that time-shares a single 1-bit full adder across all bit positions of a WIDTH-bit operand pair. It accepts one add request over a valid/ready handshake and shifts operands LSB-first through the adder, one bit per clock. It returns sum and carry-out over a second valid/ready handshake. It is the sequencing layer over the team's gate-level binary elements, trading WIDTH cycles of latency for one adder cell.

## Interface

- WIDTH, 8: operand and sum width in bits; legal range WIDTH >= 2.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  requester presents operands.
- start_ready  out  1  controller can accept; high only in IDLE.
- a_in  in  WIDTH  operand A; sampled only on accept.
- b_in  in  WIDTH  operand B; sampled only on accept.
- cin  in  1  carry-in; sampled only on accept.
- done_valid  out  1  result available; high only in DONE.
- done_ready  in  1  consumer takes the result.
- sum_out  out  WIDTH  sum shift register, always visible.
- cout  out  1  carry register, always visible.
- busy  out  1  high in RUN or DONE.

## Operation

- States are IDLE, RUN and DONE.
- IDLE to RUN: when start_valid & start_ready at an edge (the accept edge):
  - A_sr <= a_in; B_sr <= b_in; carry <= cin.
  - sum_sr <= 0; bit_cnt <= 0.
- RUN, every edge:
  - The full adder computes (s, c) = A_sr[0] + B_sr[0] + carry.
  - A_sr and B_sr shift right. sum_sr <= {s, sum_sr[WIDTH-1:1]}. carry <= c.
  - bit_cnt increments.
  - On the edge where bit_cnt == WIDTH-1, go to DONE.
- DONE: done_valid = 1. sum_out and cout are frozen. On done_ready, go to IDLE.
- Arithmetic: {cout, sum_out} = a_in + b_in + cin, exact as a (WIDTH+1)-bit result; no overflow flag.
- bit_cnt is $clog2(WIDTH) bits wide. It never wraps past WIDTH-1 within one operation.
- start_valid outside IDLE is ignored.
- done_ready outside DONE is ignored.
- Changes on a_in, b_in or cin after the accept edge have no effect.
- In DONE, done_ready and start_valid together: the controller goes to IDLE only; there is no same-cycle re-accept because start_ready = 0 in DONE.
- After the result handshake, sum_out and cout keep the last result in IDLE until the next accept edge clears sum_sr.

## Timing

- Reset values: state IDLE; start_ready 1; done_valid 0; busy 0; sum_out 0; cout 0; all internal registers 0.
- rst asserted mid-RUN or mid-DONE aborts immediately and asynchronously. No done_valid is produced for the aborted operation.
- Latency: done_valid rises after exactly WIDTH edges following the accept edge. RUN occupies WIDTH cycles.
- Throughput: one operation per WIDTH+2 cycles minimum (accept edge, WIDTH RUN edges, result handshake edge).
- start_ready, done_valid and busy are decoded from registered state only. There is no combinational path from any input to any output.

## Structure

- serial_adder_pkg holds:
  - the state typedef: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  - the default WIDTH constant.
- Sub-module full_adder: 1-bit (a, b, ci) -> (s, co), built from two half adders plus an OR. It is instantiated once, purely combinationally, inside serial_adder_ctrl.
- The controller itself holds the FSM, bit counter, operand/sum shift registers and carry flop.

## Test plan

- Reset: assert rst mid-cycle with no clock edge -> start_ready=1, done_valid=0, busy=0, sum_out=0x00, cout=0 immediately.
- WIDTH=8, a=0x5A, b=0x33, cin=0 -> sum_out=0x8D, cout=0. done_valid rises exactly 8 edges after the accept edge; busy high throughout.
- Full carry ripple, a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout=1.
- Maximum, a=0xFF, b=0xFF, cin=1 -> sum_out=0xFF, cout=1.
- Backpressure and ignored stimulus, a=0x10, b=0x20:
  - Hold done_ready=0 for 5 cycles in DONE -> done_valid and sum_out=0x30 held stable.
  - Toggle start_valid, a_in and b_in during RUN and DONE -> result unchanged; nothing accepted until IDLE.
- Abort: assert rst when bit_cnt=3 -> IDLE with reset values and no done_valid. Then a=0x01, b=0x02, cin=1 -> sum_out=0x04, cout=0.
